// File: rtl/rr_enc_pkg.sv
// Shared definitions for the round-robin 8-to-3 request encoder.
// Holds the requester count, the index width, the FSM state encoding and
// the wrapping index increment used to advance the priority pointer.
package rr_enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // 3-bit increment; 7 wraps to 0 by natural modulo arithmetic
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin winner search over eight request lines.
// The request vector is rotated right by ptr so that requester ptr lands
// on bit 0. The lowest set bit of the rotated vector is found, and ptr is
// added back (mod 8) to recover the absolute index.
module rr_pick8
    import rr_enc_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   rot_idx;

    // Doubling the vector turns the rotate into a plain variable slice
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];

    // Fixed priority on the rotated vector: the lowest set bit wins
    always_comb begin
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = IDX_W'(i);
            end
        end
    end

    assign win_idx = rot_idx + ptr;
    assign any_req = |req;

endmodule

// File: rtl/rr_encoder_8to3.sv
// Round-robin 8-to-3 request encoder with a valid/ready grant handshake.
// Converts one-of-eight requests into a registered 3-bit grant index.
// Fairness comes from a rotating pointer that moves past each served index.
// Optional feature macro: RR_ENC_ONEHOT_EN adds a registered one-hot
// copy of the grant (grant_onehot). It is zero whenever no grant is valid.
module rr_encoder_8to3
    import rr_enc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ready,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
`ifdef RR_ENC_ONEHOT_EN
    ,
    output logic [N_REQ-1:0] grant_onehot
`endif
);

    // The index width and search logic assume exactly eight requesters
    if (N_REQ != 8 || IDX_W != 3) begin : g_bad_size
        $error("rr_encoder_8to3 supports only N_REQ=8 with IDX_W=3");
    end

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] grant_idx_reg;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             transfer;
    logic             load;

    assign transfer = (state_reg == ST_GRANT) && grant_ready;

    // After a transfer, the next winner is searched from the advanced pointer
    // within the same cycle. This gives back-to-back grants with no gap.
    assign search_ptr = transfer ? idx_inc(grant_idx_reg) : ptr_reg;
    assign load       = enable && any_req && ((state_reg == ST_IDLE) || transfer);

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (search_ptr),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    // FSM, priority pointer and grant index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
        end else begin
            if (transfer) begin
                ptr_reg <= idx_inc(grant_idx_reg);
            end
            if (load) begin
                grant_idx_reg <= win_idx;
                state_reg     <= ST_GRANT;
            end else if (transfer) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign grant_valid = (state_reg == ST_GRANT);
    assign grant_idx   = grant_idx_reg;

`ifdef RR_ENC_ONEHOT_EN
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] grant_onehot_reg;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_idx == IDX_W'(gi));
    end

    // One-hot grant tracks the index register and clears when the grant retires
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_onehot_reg <= '0;
        end else if (load) begin
            grant_onehot_reg <= win_onehot;
        end else if (transfer) begin
            grant_onehot_reg <= '0;
        end
    end

    assign grant_onehot = grant_onehot_reg;
`endif

endmodule

// File: tb/tb_rr_encoder_8to3.sv
// Self-checking bench for rr_encoder_8to3.
// Expected grant indices are queued when stimulus is driven. Every
// handshake transfer pops one entry and compares it.
// Scenario tasks check valid/idx (and grant_onehot when RR_ENC_ONEHOT_EN
// is defined) directly.
module tb_rr_encoder_8to3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] req;
    logic       grant_ready;
    logic       grant_valid;
    logic [2:0] grant_idx;
`ifdef RR_ENC_ONEHOT_EN
    logic [7:0] grant_onehot;
`endif

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_pop;

    rr_encoder_8to3 dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
`ifdef RR_ENC_ONEHOT_EN
        ,
        .grant_onehot(grant_onehot)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: each accepted grant must match the oldest queued index
    always @(negedge clk) begin
        if (!reset && grant_valid === 1'b1 && grant_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got idx=%0d, expected no transfer", grant_idx);
            end else begin
                exp_pop = exp_q.pop_front();
                if (grant_idx !== exp_pop) begin
                    errors++;
                    $display("FAIL xfer_idx: got %0d, expected %0d", grant_idx, exp_pop);
                end else begin
                    $display("xfer idx=%0d ok", grant_idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic exp_v, input logic [2:0] exp_i);
        // valid and idx checks are written inline per call site name
        checks++;
        if (grant_valid !== exp_v) begin
            errors++;
            $display("FAIL %s_valid: got %b, expected %b", name, grant_valid, exp_v);
        end
        checks++;
        if (grant_idx !== exp_i) begin
            errors++;
            $display("FAIL %s_idx: got %0d, expected %0d", name, grant_idx, exp_i);
        end
    endtask

`ifdef RR_ENC_ONEHOT_EN
    task automatic check_onehot(input string name, input logic [7:0] exp_oh);
        checks++;
        if (grant_onehot !== exp_oh) begin
            errors++;
            $display("FAIL %s_onehot: got %h, expected %h", name, grant_onehot, exp_oh);
        end
    endtask
`endif

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; req = 8'h00; grant_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = 8'hFF; grant_ready = 1'b1;
        tick();
        check_out("reset_a", 1'b0, 3'd0);
        tick();
        check_out("reset_b", 1'b0, 3'd0);
`ifdef RR_ENC_ONEHOT_EN
        check_onehot("reset", 8'h00);
`endif
        reset = 1'b0; enable = 1'b0; grant_ready = 1'b0;
        tick();
        check_out("reset_release", 1'b0, 3'd0);
        $display("test_reset done");
    endtask

    task automatic test_hold();
        apply_reset();
        req = 8'b0001_0000; enable = 1'b1; grant_ready = 1'b0;
        tick();
        check_out("hold_first", 1'b1, 3'd4);
`ifdef RR_ENC_ONEHOT_EN
        check_onehot("hold", 8'h10);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("hold_stable", 1'b1, 3'd4);
        end
        exp_q.push_back(3'd4);
        grant_ready = 1'b1; req = 8'h00;
        tick();
        check_out("hold_done", 1'b0, 3'd4);
        grant_ready = 1'b0;
        $display("test_hold done");
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq;
        apply_reset();
        req = 8'hFF; enable = 1'b1; grant_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            seq = 3'(k % 8);
            exp_q.push_back(seq);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            seq = 3'(k % 8);
            check_out("b2b", 1'b1, seq);
        end
        req = 8'h00;
        tick();
        check_out("b2b_end", 1'b0, 3'd0);
        grant_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 8'b0010_0000; enable = 1'b1; grant_ready = 1'b0;
        tick();
        check_out("wrap_five", 1'b1, 3'd5);
        exp_q.push_back(3'd5);
        req = 8'b0000_0011; grant_ready = 1'b1;
        tick();
        check_out("wrap_zero", 1'b1, 3'd0);
        exp_q.push_back(3'd0);
        tick();
        check_out("wrap_one", 1'b1, 3'd1);
        exp_q.push_back(3'd1);
        req = 8'h00;
        tick();
        check_out("wrap_end", 1'b0, 3'd1);
        grant_ready = 1'b0;
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 8'h08; enable = 1'b1; grant_ready = 1'b0;
        tick();
        check_out("midrst_pend", 1'b1, 3'd3);
        reset = 1'b1;
        tick();
        check_out("midrst_rst", 1'b0, 3'd0);
`ifdef RR_ENC_ONEHOT_EN
        check_onehot("midrst", 8'h00);
`endif
        reset = 1'b0; req = 8'h88;
        tick();
        check_out("midrst_after", 1'b1, 3'd3);
        exp_q.push_back(3'd3);
        grant_ready = 1'b1; req = 8'h00;
        tick();
        check_out("midrst_end", 1'b0, 3'd3);
        grant_ready = 1'b0;
        $display("test_reset_mid_grant done");
    endtask

    task automatic test_enable();
        apply_reset();
        enable = 1'b0; req = 8'h80; grant_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("en_off", 1'b0, 3'd0);
        end
        enable = 1'b1;
        tick();
        check_out("en_on", 1'b1, 3'd7);
`ifdef RR_ENC_ONEHOT_EN
        check_onehot("en_on", 8'h80);
`endif
        exp_q.push_back(3'd7);
        grant_ready = 1'b1; req = 8'h00;
        tick();
        check_out("en_end", 1'b0, 3'd7);
`ifdef RR_ENC_ONEHOT_EN
        check_onehot("en_end", 8'h00);
`endif
        grant_ready = 1'b0;
        $display("test_enable done");
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req = 8'h00; grant_ready = 1'b0;
        test_reset();
        test_hold();
        test_back_to_back();
        test_wrap();
        test_reset_mid_grant();
        test_enable();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
